// File: rtl/fx_mul_arb_pkg.sv
// Shared helpers and default-configuration types for the fixed-point multiplier arbiter.
// The tag and count widths here follow the default N_REQ / MAX_INFLIGHT.
package fx_mul_arb_pkg;

   localparam int unsigned N_REQ_DEF        = 4;
   localparam int unsigned MAX_INFLIGHT_DEF = 8;

   // $clog2(1) is 0, but a tag still needs at least one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned IDW  = id_width(N_REQ_DEF);
   localparam int unsigned CNTW = $clog2(MAX_INFLIGHT_DEF) + 1;

   typedef logic [IDW-1:0]  tag_t;
   typedef logic [CNTW-1:0] cnt_t;

endpackage

// File: rtl/fx_mul_arbiter_if.sv
// Requester-side bus of fx_mul_arbiter: per-requester operand handshake and shared response.
// master = requester cluster, slave = arbiter.
interface fx_mul_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_REQ = 4
) ();

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]       rsp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/fx_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight product.
// Synchronous reset; push is accepted when full only if a pop happens in the same cycle.
module fx_tag_fifo
   import fx_mul_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/fx_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier among N_REQ requesters.
// Defining FX_MUL_ARB_STATS_EN adds saturating stat_busy / stat_stall cycle counters.
module fx_mul_arbiter
   import fx_mul_arb_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned MAX_INFLIGHT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   fx_mul_arbiter_if.slave               bus,
   output logic                          mul_valid_in,
   output logic [WIDTH-1:0]              mul_a,
   output logic [WIDTH-1:0]              mul_b,
   input  logic [WIDTH-1:0]              mul_result,
   input  logic                          mul_valid_out,
   output logic [$clog2(MAX_INFLIGHT):0] inflight,
   output logic                          err_orphan
`ifdef FX_MUL_ARB_STATS_EN
   ,
   output logic [31:0]                   stat_busy,
   output logic [31:0]                   stat_stall
`endif
);

   localparam int unsigned TAGW = id_width(N_REQ);
   localparam int unsigned INFW = $clog2(MAX_INFLIGHT) + 1;

   logic [TAGW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [INFW-1:0]  inflight_q, inflight_d;
   logic             mul_valid_in_q, mul_valid_in_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             err_orphan_q, err_orphan_d;

   logic             can_issue;
   logic             grant_found;
   logic [TAGW-1:0]  grant_idx;
   logic [TAGW-1:0]  cand;
   logic [N_REQ-1:0] req_ready;
   logic [WIDTH-1:0] win_a, win_b;
   logic             xfer;
   logic             fifo_push, fifo_pop;
   logic             fifo_empty, fifo_full;
   logic [TAGW-1:0]  fifo_dout;

   // A pop in this cycle only frees its credit on the following cycle.
   assign can_issue = (inflight_q < INFW'(MAX_INFLIGHT)) && !fifo_full;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = TAGW'((32'(rr_ptr_q) + k) % N_REQ);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Ready is held low under reset so no transfer is lost to the reset edge.
   always_comb begin
      req_ready = '0;
      win_a     = '0;
      win_b     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_idx == TAGW'(i)) begin
            win_a        = bus.req_a[i*WIDTH +: WIDTH];
            win_b        = bus.req_b[i*WIDTH +: WIDTH];
            req_ready[i] = grant_found && can_issue && !rst;
         end
      end
   end

   assign xfer      = |(req_ready & bus.req_valid);
   assign fifo_push = xfer;
   assign fifo_pop  = mul_valid_out && !fifo_empty;

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      mul_valid_in_d = xfer;
      mul_a_d        = mul_a_q;
      mul_b_d        = mul_b_q;
      if (xfer) begin
         mul_a_d  = win_a;
         mul_b_d  = win_b;
         rr_ptr_d = (grant_idx == TAGW'(N_REQ - 1)) ? '0 : grant_idx + TAGW'(1);
      end

      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (fifo_pop) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = (fifo_dout == TAGW'(i));
         end
         rsp_data_d = mul_result;
      end

      err_orphan_d = err_orphan_q || (mul_valid_out && fifo_empty);
      inflight_d   = inflight_q + INFW'(fifo_push) - INFW'(fifo_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q       <= '0;
         inflight_q     <= '0;
         mul_valid_in_q <= 1'b0;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         rsp_valid_q    <= '0;
         rsp_data_q     <= '0;
         err_orphan_q   <= 1'b0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         inflight_q     <= inflight_d;
         mul_valid_in_q <= mul_valid_in_d;
         mul_a_q        <= mul_a_d;
         mul_b_q        <= mul_b_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         err_orphan_q   <= err_orphan_d;
      end
   end

   fx_tag_fifo #(
      .DEPTH (MAX_INFLIGHT),
      .W     (TAGW)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (grant_idx),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign mul_valid_in  = mul_valid_in_q;
   assign mul_a         = mul_a_q;
   assign mul_b         = mul_b_q;
   assign inflight      = inflight_q;
   assign err_orphan    = err_orphan_q;

`ifdef FX_MUL_ARB_STATS_EN
   logic [31:0] stat_busy_q, stat_busy_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_busy_d  = stat_busy_q;
      stat_stall_d = stat_stall_q;
      if ((inflight_q != '0) && (stat_busy_q != '1)) begin
         stat_busy_d = stat_busy_q + 32'd1;
      end
      if ((|bus.req_valid) && !can_issue && (stat_stall_q != '1)) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_busy_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_busy_q  <= stat_busy_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_busy  = stat_busy_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fx_mul_arbiter.sv
// Bench for fx_mul_arbiter: directed and random requester traffic against a queue-based
// reference model, with a Q16.16 multiplier of selectable latency emulated here.
module tb_fx_mul_arbiter;

   localparam int unsigned W    = 32;
   localparam int unsigned NR   = 4;
   localparam int unsigned MAXI = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fx_mul_arbiter_if #(.WIDTH(W), .N_REQ(NR)) bus ();

   logic                  mul_valid_in;
   logic [W-1:0]          mul_a, mul_b;
   logic [W-1:0]          mul_result;
   logic                  mul_valid_out;
   logic [$clog2(MAXI):0] inflight;
   logic                  err_orphan;
`ifdef FX_MUL_ARB_STATS_EN
   logic [31:0]           stat_busy, stat_stall;
`endif

   logic [NR-1:0] rv;
   logic [W-1:0]  ra [NR];
   logic [W-1:0]  rb [NR];

   assign bus.req_valid = rv;
   assign bus.req_a     = {ra[3], ra[2], ra[1], ra[0]};
   assign bus.req_b     = {rb[3], rb[2], rb[1], rb[0]};

   fx_mul_arbiter #(
      .WIDTH        (W),
      .N_REQ        (NR),
      .MAX_INFLIGHT (MAXI)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .mul_valid_in  (mul_valid_in),
      .mul_a         (mul_a),
      .mul_b         (mul_b),
      .mul_result    (mul_result),
      .mul_valid_out (mul_valid_out),
      .inflight      (inflight),
      .err_orphan    (err_orphan)
`ifdef FX_MUL_ARB_STATS_EN
      ,
      .stat_busy     (stat_busy),
      .stat_stall    (stat_stall)
`endif
   );

   function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [63:0] p;
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return p[47:16];
   endfunction

   // Shared multiplier: fixed-latency pipeline, deliberately not reset with the DUT.
   int unsigned  lat = 3;
   logic         pv [16] = '{default: 1'b0};
   logic [W-1:0] pd [16] = '{default: '0};

   always @(posedge clk) begin
      for (int i = 15; i > 0; i--) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
      pv[0] <= (mul_valid_in === 1'b1);
      pd[0] <= qmul(mul_a, mul_b);
   end

   assign mul_valid_out = pv[lat-1];
   assign mul_result    = pd[lat-1];

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model state
   int           m_ptr, m_inflight;
   bit           m_err;
   logic         e_mvi;
   logic [W-1:0] e_ma, e_mb, e_rspd;
   logic [NR-1:0] e_rspv;
   int unsigned  m_busy, m_stall;
   int           tag_id [$];
   logic [W-1:0] tag_prod [$];
   longint       ret_due [$];
   longint       cyc;
   int           last_grant;

   task automatic model_reset();
      m_ptr = 0; m_inflight = 0; m_err = 1'b0;
      e_mvi = 1'b0; e_ma = '0; e_mb = '0; e_rspd = '0; e_rspv = '0;
      m_busy = 0; m_stall = 0;
      tag_id.delete(); tag_prod.delete();
   endtask

   // Called at a falling edge with this cycle's inputs applied.
   task automatic tick();
      int g;
      bit can, due;
      logic [NR-1:0] exp_rdy;
      #1;
      can = (m_inflight < MAXI);
      g = -1;
      if (!rst && can) begin
         for (int k = 0; k < NR; k++) begin
            if (g < 0 && rv[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
         end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;

      chk("req_ready",    bus.req_ready, exp_rdy);
      chk("mul_valid_in", mul_valid_in,  e_mvi);
      chk("mul_a",        mul_a,         e_ma);
      chk("mul_b",        mul_b,         e_mb);
      chk("rsp_valid",    bus.rsp_valid, e_rspv);
      chk("rsp_data",     bus.rsp_data,  e_rspd);
      chk("inflight",     inflight,      m_inflight);
      chk("err_orphan",   err_orphan,    m_err);
`ifdef FX_MUL_ARB_STATS_EN
      chk("stat_busy",    stat_busy,     m_busy);
      chk("stat_stall",   stat_stall,    m_stall);
`endif

      due = (ret_due.size() > 0 && ret_due[0] == cyc);
      if (due) void'(ret_due.pop_front());

      if (rst) begin
         model_reset();
      end else begin
         if (m_inflight != 0 && m_busy != 32'hFFFF_FFFF) m_busy++;
         if (rv != '0 && !can && m_stall != 32'hFFFF_FFFF) m_stall++;
         e_rspv = '0;
         if (due) begin
            if (tag_id.size() > 0) begin
               e_rspv = 4'b0001 << tag_id.pop_front();
               e_rspd = tag_prod.pop_front();
               m_inflight--;
            end else begin
               m_err = 1'b1;
            end
         end
         if (g >= 0) begin
            e_mvi = 1'b1;
            e_ma  = ra[g];
            e_mb  = rb[g];
            tag_id.push_back(g);
            tag_prod.push_back(qmul(ra[g], rb[g]));
            ret_due.push_back(cyc + 1 + lat);
            m_ptr = (g + 1) % NR;
            m_inflight++;
         end else begin
            e_mvi = 1'b0;
         end
      end
      last_grant = g;
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      rv  = '0;
      for (int i = 0; i < NR; i++) begin
         ra[i] = '0;
         rb[i] = '0;
      end
      cyc = 0;
      last_grant = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;

      // Single Q16.16 request: 1.5 * 2.0
      ra[0] = 32'h0001_8000; rb[0] = 32'h0002_0000; rv = 4'b0001;
      tick();
      rv = '0;
      repeat (6) tick();

      // Signed request from requester 2: -1.0 * 0.5
      ra[2] = 32'hFFFF_0000; rb[2] = 32'h0000_8000; rv = 4'b0100;
      tick();
      rv = '0;
      repeat (6) tick();

      // All requesters held valid: round-robin at full rate
      for (int i = 0; i < NR; i++) begin
         ra[i] = $urandom; rb[i] = $urandom;
      end
      rv = 4'b1111;
      repeat (12) begin
         tick();
         if (last_grant >= 0) begin
            ra[last_grant] = $urandom;
            rb[last_grant] = $urandom;
         end
      end
      rv = '0;
      repeat (20) tick();

      // Credit exhaustion: latency longer than the in-flight budget
      lat = 6;
      rv = 4'b1111;
      repeat (20) begin
         tick();
         if (last_grant >= 0) begin
            ra[last_grant] = $urandom;
            rb[last_grant] = $urandom;
         end
      end
      rv = '0;
      repeat (20) tick();
      lat = 3;

      // Random traffic, including requesters withdrawing before acceptance
      repeat (60) begin
         for (int i = 0; i < NR; i++) begin
            if (!rv[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  rv[i] = 1'b1;
                  ra[i] = $urandom;
                  rb[i] = $urandom;
               end
            end else if ($urandom_range(7, 0) == 0) begin
               rv[i] = 1'b0;
            end
         end
         tick();
         if (last_grant >= 0) rv[last_grant] = 1'b0;
      end
      rv = '0;
      repeat (20) tick();

      // Reset with three products in flight; stale returns become orphans
      lat = 6;
      for (int i = 0; i < NR; i++) begin
         ra[i] = $urandom; rb[i] = $urandom;
      end
      rv = 4'b0111;
      repeat (3) begin
         tick();
         if (last_grant >= 0) rv[last_grant] = 1'b0;
      end
      rv = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      repeat (10) tick();
      lat = 3;

      // Requester 1 withdraws just before its turn and must be skipped
      ra[0] = $urandom; rb[0] = $urandom;
      ra[1] = $urandom; rb[1] = $urandom;
      ra[2] = $urandom; rb[2] = $urandom;
      rv = 4'b0011;
      tick();
      rv = 4'b0100;
      tick();
      rv = '0;
      repeat (8) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fx_mul_arbiter.md
Name: fx_mul_arbiter

Overview:
- Shares one pipelined fixed-point multiplier among N_REQ requesters using round-robin arbitration.
- Registers the winning operand pair into the multiplier and records the winner's ID in an in-order tag FIFO.
- Routes each multiplier result back to the requester that issued it.
- Sits between the QMC/LSM regression datapath clients (path-step, basis-function, payoff units) and the single shared multiplier instance.

Parameters:
- WIDTH, 32, operand/result width (signed, QINT.QFRAC).
- N_REQ, 4, number of requesters (2..16).
- MAX_INFLIGHT, 8, max issued-but-unreturned products; power of 2, >= 2. Full throughput requires MAX_INFLIGHT >= multiplier latency + 1.
- IDW, $clog2(N_REQ), tag width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester operand-pair valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B; same slicing as req_a.
- rsp_valid  out  N_REQ  one-hot pulse; result for requester i is valid.
- rsp_data  out  WIDTH  result, shared by all requesters.
- mul_valid_in  out  1  launch pulse to the multiplier.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_result  in  WIDTH  product from the multiplier.
- mul_valid_out  in  1  product-valid pulse from the multiplier.
- inflight  out  $clog2(MAX_INFLIGHT)+1  current outstanding count.
- err_orphan  out  1  sticky: a mul_valid_out arrived with the tag FIFO empty.

Behaviour:
- Reset: the following are cleared to 0 on the first clk edge with rst=1:
  - outputs: req_ready, rsp_valid, rsp_data, mul_valid_in, mul_a, mul_b, inflight, err_orphan;
  - internal state: round-robin pointer, tag FIFO pointers.
- Reset mid-operation: all in-flight tags are discarded. Products returning after reset hit an empty FIFO, are dropped, and set err_orphan. The system resets the multiplier together with this block, so this case only arises if that tie is broken.
- can_issue = (inflight < MAX_INFLIGHT). The FIFO-pop in the same cycle does not create a credit until the next cycle.
- Grant (combinational):
  - Search begins at rr_ptr and wraps modulo N_REQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready = one-hot(winner) & can_issue; req_ready=0 when no request is valid or credits are exhausted.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold valid and operands stable until accepted.
  - Deasserting valid before acceptance is permitted; that requester simply forfeits the slot.
- Issue, on the edge after a transfer:
  - mul_valid_in=1; mul_a/mul_b = winner's operands.
  - Winner ID is pushed to the tag FIFO.
  - inflight += 1.
  - rr_ptr = (winner+1) mod N_REQ.
- With no transfer: mul_valid_in=0, mul_a/mul_b hold, rr_ptr holds.
- Throughput: at most one issue per cycle, back-to-back allowed.
- Return, on mul_valid_out=1 with the FIFO non-empty:
  - The head tag is popped.
  - Next edge: rsp_valid = one-hot(tag), rsp_data = mul_result, inflight -= 1.
  - Response latency: 1 cycle after mul_valid_out.
- Return with the FIFO empty: the result is dropped, err_orphan=1 (sticky until rst), inflight unchanged.
- Simultaneous issue and return in the same cycle: push and pop both occur and inflight is unchanged.
- No response backpressure: requesters must accept rsp_valid unconditionally.
- Ordering: results return in issue order; the multiplier is strictly in-order.
- rsp_data holds its last value when rsp_valid=0.

Optional Feature:
- Macro: FX_MUL_ARB_STATS_EN.
- Defined:
  - Adds output stat_busy (32 bits): cycles with inflight != 0.
  - Adds output stat_stall (32 bits): cycles with any req_valid but can_issue=0.
  - Both counters saturate at all-ones and are cleared by rst.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package fx_mul_arb_pkg holds:
  - localparam IDW helper function (clog2-safe for N_REQ=1);
  - typedef tag_t (logic [IDW-1:0]);
  - typedef cnt_t for inflight.
- Sub-module fx_tag_fifo: synchronous-reset FIFO, depth MAX_INFLIGHT, width IDW.
  - Ports: push/pop/din/dout/empty/full.
  - Simultaneous push and pop are legal when full or empty+push.

Test Plan:
- Single request, Q16.16: req 0 issues a=0x00018000, b=0x00020000 (1.5*2.0). Expect rsp_valid=0001, rsp_data=0x00030000; inflight goes 1 then returns to 0.
- Signed request: req 2 issues a=0xFFFF0000, b=0x00008000 (-1.0*0.5). Expect rsp_valid=0100, rsp_data=0xFFFF8000.
- All 4 requesters held valid continuously for 12 cycles. Expect grants in order 0,1,2,3,0,1,2,3, one per cycle, and responses returned in the same order with correct per-requester products.
- MAX_INFLIGHT=2 with the multiplier latency set to 4, requests held continuously. Expect req_ready low whenever inflight=2, and stat_busy/stat_stall counts matching a hand computation when FX_MUL_ARB_STATS_EN is set.
- Assert rst for one cycle with 3 products in flight. Expect all outputs 0 after the reset edge; expect err_orphan=1 when the stale mul_valid_out arrives, and no rsp_valid pulse.
- Requester 1 deasserts req_valid one cycle before its turn. Expect rr_ptr to skip it, no issue for requester 1, and no spurious response.
